// File: rtl/push_sw_sequencer.sv
// push_sw_sequencer: front end for the push-switch pattern detector.
// Synchronises and debounces the two raw switches, turns each accepted press
// into a symbol (LEFT=0, RIGHT=1), queues symbols in a small FWFT FIFO for the
// detector's valid/ready port, and stretches the detector's match pulse for an LED.
module push_sw_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int LED_HOLD        = 8
) (
    input  logic clk,
    input  logic rstb,
    input  logic PUSH_SW_LEFT,
    input  logic PUSH_SW_RIGHT,
    output logic sym_valid,
    output logic sym_bit,
    input  logic sym_ready,
    input  logic det_match,
    output logic LED,
    output logic overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [7:0]    DB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   HOLD_C  = 16'(LED_HOLD);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Index 0 is the left switch, index 1 the right switch.
    logic [1:0] sw_raw;
    logic [1:0] sw_s1;
    logic [1:0] sw_s2;
    logic [1:0] armed;
    logic [1:0] press_ev;
    logic [1:0] warm;
    logic       sync_ok;
    db_state_t  db_state [2];
    logic [7:0] db_cnt   [2];
    logic [7:0] cnt_inc  [2];

    logic [FIFO_DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         wr_ptr_nx;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  rr_ptr;
    logic                  pop;
    logic                  both;
    logic                  sym_a;
    logic                  sym_b;
    logic [1:0]            req_n;
    logic [1:0]            wr_n;
    logic                  drop;

    logic [15:0] hold;
    logic [15:0] hold_nx;

    assign sw_raw  = {PUSH_SW_RIGHT, PUSH_SW_LEFT};
    // s2 only carries a real switch sample once both sync flops have been
    // loaded after reset; before that its zero is just the reset value.
    assign sync_ok = warm[1];

    // Press events fire on the edge where the press counter reaches its target.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_inc[i]  = db_cnt[i] + 8'd1;
            press_ev[i] = (db_state[i] == PRESS_WAIT) && sw_s2[i] && (cnt_inc[i] == DB_LAST);
        end
    end

    // Two-flop synchronisers, post-reset arming and one debounce FSM per switch.
    // A switch held through reset stays disarmed until it is seen released, so
    // reset release never produces a symbol on its own.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            armed <= '0;
            warm  <= '0;
            for (int i = 0; i < 2; i++) begin
                db_state[i] <= RELEASED;
                db_cnt[i]   <= '0;
            end
        end else begin
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
            if (!warm[1]) warm <= warm + 2'd1;
            for (int i = 0; i < 2; i++) begin
                if (sync_ok && !sw_s2[i]) armed[i] <= 1'b1;
                case (db_state[i])
                    RELEASED: begin
                        if (armed[i] && sw_s2[i]) begin
                            db_state[i] <= PRESS_WAIT;
                            db_cnt[i]   <= 8'd1;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sw_s2[i]) begin
                            db_state[i] <= RELEASED;
                            db_cnt[i]   <= '0;
                        end else if (cnt_inc[i] == DB_LAST) begin
                            db_state[i] <= PRESSED;
                            db_cnt[i]   <= '0;
                        end else begin
                            db_cnt[i] <= cnt_inc[i];
                        end
                    end
                    PRESSED: begin
                        if (!sw_s2[i]) begin
                            db_state[i] <= RELEASE_WAIT;
                            db_cnt[i]   <= 8'd1;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sw_s2[i]) begin
                            db_state[i] <= PRESSED;
                            db_cnt[i]   <= '0;
                        end else if (cnt_inc[i] == DB_LAST) begin
                            db_state[i] <= RELEASED;
                            db_cnt[i]   <= '0;
                        end else begin
                            db_cnt[i] <= cnt_inc[i];
                        end
                    end
                    default: begin
                        db_state[i] <= RELEASED;
                        db_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Arbitration and write sizing: a same-edge pop frees a slot for the writes,
    // and when only one slot is free the first-ordered symbol wins.
    always_comb begin
        pop       = sym_valid && sym_ready;
        both      = press_ev[0] && press_ev[1];
        sym_a     = both ? rr_ptr : press_ev[1];
        sym_b     = ~rr_ptr;
        req_n     = {1'b0, press_ev[0]} + {1'b0, press_ev[1]};
        free      = DEPTH_C - count + CW'(pop);
        wr_ptr_nx = wr_ptr + 1'b1;
        wr_n      = 2'd0;
        if (req_n == 2'd2 && free >= CW'(2)) begin
            wr_n = 2'd2;
        end else if (req_n != 2'd0 && free != '0) begin
            wr_n = 2'd1;
        end
        drop = (req_n > wr_n);
    end

    // Symbol FIFO, round-robin pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_n != 2'd0) mem[wr_ptr] <= sym_a;
            if (wr_n == 2'd2) mem[wr_ptr_nx] <= sym_b;
            wr_ptr <= wr_ptr + PW'(wr_n);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_n) - CW'(pop);
            if (both) rr_ptr <= ~rr_ptr;
            if (drop) overflow <= 1'b1;
        end
    end

    assign sym_valid = (count != '0);
    assign sym_bit   = sym_valid & mem[rd_ptr];

    // Next hold value: a match reloads the full on-time, otherwise count down.
    always_comb begin
        hold_nx = hold;
        if (det_match) begin
            hold_nx = HOLD_C;
        end else if (hold != 16'd0) begin
            hold_nx = hold - 16'd1;
        end
    end

    // LED stretcher: LED tracks a nonzero hold count, registered alongside it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold <= '0;
            LED  <= 1'b0;
        end else begin
            hold <= hold_nx;
            LED  <= (hold_nx != 16'd0);
        end
    end

endmodule

// File: tb/tb_push_sw_sequencer.sv
// Directed testbench for push_sw_sequencer (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, LED_HOLD=8).
module tb_push_sw_sequencer;
    logic clk       = 1'b0;
    logic rstb      = 1'b1;
    logic sw_l      = 1'b0;
    logic sw_r      = 1'b0;
    logic sym_ready = 1'b0;
    logic det_match = 1'b0;
    logic sym_valid;
    logic sym_bit;
    logic led;
    logic overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic got_q[$];
    logic seen;

    push_sw_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4),
        .LED_HOLD       (8)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .PUSH_SW_LEFT (sw_l),
        .PUSH_SW_RIGHT(sw_r),
        .sym_valid    (sym_valid),
        .sym_bit      (sym_bit),
        .sym_ready    (sym_ready),
        .det_match    (det_match),
        .LED          (led),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Records the symbol popped at the coming edge, then steps to 1 ns after it.
    task automatic tick();
        if (sym_valid && sym_ready) got_q.push_back(sym_bit);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic l, input logic r);
        sw_l = l;
        sw_r = r;
        ticks(8);
        sw_l = 1'b0;
        sw_r = 1'b0;
        ticks(8);
    endtask

    task automatic check_seq(input string tag, input logic [3:0] exp, input int n);
        check({tag, "_len"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_%0d", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'd2, 32'(exp[i]));
    endtask

    initial begin
        // Reset with switches toggling
        #2 rstb = 1'b0;
        #1;
        check("rst_valid", sym_valid, 0);
        check("rst_bit", sym_bit, 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            sw_l = ~sw_l;
            sw_r = (c == 0);
            check($sformatf("rst_valid_c%0d", c), sym_valid, 0);
            check($sformatf("rst_led_c%0d", c), led, 0);
            check($sformatf("rst_ovf_c%0d", c), overflow, 0);
        end
        sw_l = 1'b0;
        sw_r = 1'b0;
        rstb = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (sym_valid || led || overflow) seen = 1'b1;
        end
        check("idle_after_rst", seen, 0);

        // One-cycle glitch gives nothing
        got_q.delete();
        sym_ready = 1'b1;
        sw_l = 1'b1;
        tick();
        sw_l = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sym_valid) seen = 1'b1;
        end
        check("glitch_no_valid", seen, 0);
        check("glitch_no_sym", 32'(got_q.size()), 0);

        // Latency of a clean left press
        got_q.delete();
        sw_l = 1'b1;
        ticks(5);
        check("lat_pre", sym_valid, 0);
        tick();
        check("lat_valid", sym_valid, 1);
        check("lat_bit", sym_bit, 0);
        tick();
        check("lat_one_cycle", sym_valid, 0);
        tick();
        sw_l = 1'b0;
        ticks(8);
        check_seq("lat", 4'b0000, 1);

        // Clean presses L, R, R, L
        got_q.delete();
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check_seq("clean", 4'b0110, 4);
        check("clean_ovf", overflow, 0);

        // Simultaneous presses with the detector stalled, then an overflow
        got_q.delete();
        sym_ready = 1'b0;
        press(1'b1, 1'b1);
        check("dbl1_head", sym_bit, 0);
        press(1'b1, 1'b1);
        check("full_valid", sym_valid, 1);
        check("full_ovf", overflow, 0);
        press(1'b1, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_head", sym_bit, 0);
        sym_ready = 1'b1;
        ticks(8);
        check_seq("drain", 4'b0110, 4);
        check("drain_empty", sym_valid, 0);
        check("ovf_sticky", overflow, 1);

        // LED stretcher: single pulse, then a retrigger at cycle 5
        check("led_idle", led, 0);
        for (int k = 0; k <= 10; k++) begin
            det_match = (k == 0);
            tick();
            check($sformatf("led1_c%0d", k + 1), led, 32'((k + 1) <= 8));
        end
        ticks(4);
        for (int k = 0; k <= 15; k++) begin
            det_match = (k == 0) || (k == 5);
            tick();
            check($sformatf("led2_c%0d", k + 1), led, 32'((k + 1) <= 13));
        end
        det_match = 1'b0;

        // Reset mid-operation with LEFT held across release
        got_q.delete();
        sym_ready = 1'b0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("q3_valid", sym_valid, 1);
        check("q3_head", sym_bit, 0);
        det_match = 1'b1;
        tick();
        det_match = 1'b0;
        check("pre_rst_led", led, 1);
        check("pre_rst_ovf", overflow, 1);
        sw_l = 1'b1;
        ticks(2);
        #4 rstb = 1'b0;
        #1;
        check("async_valid", sym_valid, 0);
        check("async_led", led, 0);
        check("async_ovf", overflow, 0);
        @(posedge clk);
        #4 rstb = 1'b1;
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
        got_q.delete();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sym_valid) seen = 1'b1;
        end
        check("held_no_valid", seen, 0);
        check("held_no_sym", 32'(got_q.size()), 0);
        sw_l = 1'b0;
        ticks(8);
        press(1'b1, 1'b0);
        check_seq("after_rst", 4'b0000, 1);
        check("after_rst_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/push_sw_sequencer.md
Name: push_sw_sequencer

Overview:
Front-end controller for the push-switch pattern-detector path. It does the following:
- Synchronises and debounces PUSH_SW_LEFT and PUSH_SW_RIGHT.
- Converts each debounced press into one symbol (LEFT=0, RIGHT=1).
- Arbitrates simultaneous presses and queues symbols in a small FIFO.
- Issues symbols to the downstream detector over a valid/ready handshake.
- Stretches the detector's one-cycle match pulse into a visible LED on-time.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-high/low cycles needed to accept a level change; legal range 2..255.
FIFO_DEPTH, 4, symbol queue depth; power of two, minimum 2.
LED_HOLD, 8, LED on-time in clk cycles after a match; legal range 1..65535.

Ports:
clk  input  1  system clock, all state on rising edge
rstb  input  1  asynchronous active-low reset
PUSH_SW_LEFT  input  1  raw left switch, asynchronous, active high
PUSH_SW_RIGHT  input  1  raw right switch, asynchronous, active high
sym_valid  output  1  FIFO head valid
sym_bit  output  1  FIFO head symbol (0=LEFT, 1=RIGHT)
sym_ready  input  1  detector accepts symbol this cycle
det_match  input  1  one-cycle pulse from detector on pattern hit
LED  output  1  stretched match indicator
overflow  output  1  sticky: a press was dropped because the FIFO was full

Behaviour:
- Clock/reset: single clock clk. rstb is asynchronous, active low. While rstb=0, all registers clear immediately:
  - sync flops 0, debounce FSMs RELEASED, counters 0, FIFO empty, rr_ptr=LEFT.
  - Outputs: sym_valid=0, sym_bit=0, LED=0, overflow=0.
- Synchroniser: two-flop chain per switch; downstream logic uses only the second flop (s2).
- Debounce FSM, one per switch: states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; 8-bit counter cnt.
  - RELEASED, s2=1: go to PRESS_WAIT, cnt=1.
  - PRESS_WAIT, s2=1: cnt++. On the edge where cnt would reach DEBOUNCE_CYCLES: go to PRESSED and raise press event (FIFO write on that same edge).
  - PRESS_WAIT, s2=0: go to RELEASED, cnt=0.
  - PRESSED, s2=0: go to RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT, s2=0: cnt++; at DEBOUNCE_CYCLES go to RELEASED.
  - RELEASE_WAIT, s2=1: go back to PRESSED, cnt=0, no new event.
  - Exactly one event per accepted press; holding a switch never repeats.
- Latency: raw switch first sampled high at edge E1 and held high → sym_valid=1 after edge E(DEBOUNCE_CYCLES+2), provided the FIFO was empty.
- Arbitration: when both events fire on the same edge, both symbols are written that edge.
  - Order set by rr_ptr: LEFT first when rr_ptr=LEFT, RIGHT first otherwise.
  - rr_ptr toggles after every simultaneous event; single events leave it unchanged.
- FIFO: first-word-fall-through. sym_bit = head entry whenever sym_valid=1.
  - Pop on sym_valid & sym_ready; head data stays stable while sym_valid=1 and sym_ready=0.
  - Free slots this cycle = FIFO_DEPTH − count + pop, so a pop frees a slot for a same-edge write.
  - Writes beyond free slots are dropped: the higher-priority symbol is kept, the other dropped.
  - Any drop sets overflow; overflow stays 1 until reset.
  - count = count + writes − pop; it never exceeds FIFO_DEPTH or underflows.
  - Pointers wrap modulo FIFO_DEPTH.
- LED stretcher: 16-bit down-counter hold.
  - det_match=1 loads hold=LED_HOLD.
  - Otherwise hold decrements if nonzero.
  - LED = (hold != 0), registered; LED rises on the edge after det_match.
  - A retrigger reloads the counter and does not extend cumulatively.
- Reset mid-operation: queued symbols and in-progress debounce are discarded; no event is generated on reset release even if a switch is held. The first press is accepted only after a fresh RELEASED→PRESS_WAIT→PRESSED path.

Test Plan:
- Reset (DEBOUNCE_CYCLES=4) → rstb=0 for 2 cycles, switches toggling: sym_valid=0, LED=0, overflow=0 throughout; they stay 0 with rstb=1 and switches low.
- LEFT high 1 cycle (10 ns), as a 1-cycle glitch → no symbol. LEFT held 8 cycles, sym_ready=1 → exactly one symbol, sym_bit=0; sym_valid high for 1 cycle, rising after the 6th edge from first sample.
- Clean presses L, R, R, L, each 8 cycles high / 8 low, sym_ready=1 → symbols 0,1,1,0 in order, overflow=0.
- sym_ready=0; both switches pressed together twice → FIFO holds 0,1,1,0 (rr_ptr flips between the two events). One more LEFT press → overflow=1, contents unchanged. Then sym_ready=1 → drains 0,1,1,0; overflow still 1.
- det_match pulse at cycle 0 → LED=1 for cycles 1–8. Second pulse at cycle 5 → LED continuous through cycle 13, then 0.
- Three symbols queued and LED on; rstb pulsed low mid-cycle → sym_valid, LED, overflow drop to 0 immediately, without waiting for a clock edge. LEFT held across reset release → no symbol until it is released and pressed again.
